// File: rtl/input_conditioner.sv
// Synchronizes and debounces WIDTH asynchronous input pins against a TICK time base,
// producing registered levels plus one-cycle rise/fall pulses and a combined change strobe.
module input_conditioner #(
  parameter int unsigned         WIDTH          = 4,
  parameter int unsigned         DEBOUNCE_TICKS = 5000,
  parameter logic [WIDTH-1:0]    RESET_VAL      = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TICK,
  input  logic [WIDTH-1:0] RAW_IN,
  output logic [WIDTH-1:0] OUT_LEVEL,
  output logic [WIDTH-1:0] OUT_RISE,
  output logic [WIDTH-1:0] OUT_FALL,
  output logic             OUT_CHANGED
);

  localparam int unsigned   CW       = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  typedef enum logic {
    ST_STABLE,
    ST_PENDING
  } ch_state_e;

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  always_comb begin
    ch_state_e st;
    sync1_d  = RAW_IN;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      st = (sync2_q[i] == stable_q[i]) ? ST_STABLE : ST_PENDING;
      case (st)
        ST_STABLE: cnt_d[i] = '0;
        ST_PENDING: begin
          if (!TICK) begin
            cnt_d[i] = cnt_q[i];
          end else if (cnt_q[i] == CNT_LAST) begin
            // Acceptance clears the counter, so it can never pass CNT_LAST.
            stable_d[i] = sync2_q[i];
            rise_d[i]   = sync2_q[i];
            fall_d[i]   = ~sync2_q[i];
            cnt_d[i]    = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: cnt_d[i] = '0;
      endcase
    end
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q   <= RESET_VAL;
      sync2_q   <= RESET_VAL;
      stable_q  <= RESET_VAL;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign OUT_LEVEL   = stable_q;
  assign OUT_RISE    = rise_q;
  assign OUT_FALL    = fall_q;
  assign OUT_CHANGED = changed_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: a tick-counting reference model predicts
// acceptance events into a queue; a negedge monitor compares the DUT against it.
module tb_input_conditioner;

  localparam int unsigned W  = 4;
  localparam int unsigned DT = 4;

  logic         CLK;
  logic         RST;
  logic         TICK;
  logic [W-1:0] RAW_IN;
  logic [W-1:0] OUT_LEVEL;
  logic [W-1:0] OUT_RISE;
  logic [W-1:0] OUT_FALL;
  logic         OUT_CHANGED;

  input_conditioner #(
    .WIDTH(W),
    .DEBOUNCE_TICKS(DT),
    .RESET_VAL(4'b0000)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .TICK(TICK),
    .RAW_IN(RAW_IN),
    .OUT_LEVEL(OUT_LEVEL),
    .OUT_RISE(OUT_RISE),
    .OUT_FALL(OUT_FALL),
    .OUT_CHANGED(OUT_CHANGED)
  );

  typedef struct {
    int unsigned  cyc;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } ev_t;

  ev_t          sbq[$];
  int unsigned  n_checks;
  int unsigned  n_fail;
  int unsigned  cyc;
  logic [W-1:0] m_lvl;
  logic [W-1:0] m_hist0, m_hist1, m_seen, m_r, m_f;
  int unsigned  m_ticks [W];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  initial begin
    CLK = 1'b0;
    forever #10 CLK = ~CLK;
  end

  // 1 MHz tick at 50 MHz clock: one cycle in fifty.
  initial begin
    int unsigned tcnt;
    tcnt = 0;
    TICK = 1'b0;
    forever begin
      @(negedge CLK);
      tcnt = (tcnt == 49) ? 0 : tcnt + 1;
      TICK = (tcnt == 49);
    end
  end

  // Reference: a pin level is seen by the debouncer two clock edges after it is sampled;
  // a disagreement that survives DT ticks is accepted, any agreement forgets the ticks.
  initial begin
    m_lvl = '0; m_hist0 = '0; m_hist1 = '0; cyc = 0;
    for (int i = 0; i < W; i++) m_ticks[i] = 0;
    forever begin
      @(posedge CLK or posedge RST);
      cyc++;
      if (RST) begin
        m_lvl = '0; m_hist0 = '0; m_hist1 = '0;
        for (int i = 0; i < W; i++) m_ticks[i] = 0;
        sbq.delete();
      end else begin
        m_seen  = m_hist1;
        m_hist1 = m_hist0;
        m_hist0 = RAW_IN;
        m_r = '0;
        m_f = '0;
        for (int i = 0; i < W; i++) begin
          if (m_seen[i] != m_lvl[i]) begin
            if (TICK) begin
              m_ticks[i]++;
              if (m_ticks[i] == DT) begin
                m_lvl[i]   = m_seen[i];
                m_ticks[i] = 0;
                if (m_seen[i]) m_r[i] = 1'b1;
                else           m_f[i] = 1'b1;
              end
            end
          end else begin
            m_ticks[i] = 0;
          end
        end
        if ((m_r | m_f) != '0) sbq.push_back('{cyc, m_r, m_f});
      end
    end
  end

  initial begin
    ev_t  ev;
    logic dut_ev, due;
    forever begin
      @(negedge CLK);
      dut_ev = OUT_CHANGED || (OUT_RISE != '0) || (OUT_FALL != '0);
      due    = (sbq.size() > 0) && (sbq[0].cyc <= cyc);
      if (dut_ev || due) begin
        if (sbq.size() == 0) begin
          check("unexpected_event", {OUT_CHANGED, 3'b000, OUT_FALL, OUT_RISE}, 32'h0);
        end else begin
          ev = sbq.pop_front();
          check("event_cycle", cyc, ev.cyc);
          check("rise", OUT_RISE, ev.rise);
          check("fall", OUT_FALL, ev.fall);
          check("changed", OUT_CHANGED, ((ev.rise | ev.fall) != '0));
        end
      end
      check("level", OUT_LEVEL, m_lvl);
    end
  end

  task automatic after_tick();
    @(posedge CLK);
    while (!TICK) @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    int unsigned guard;
    n_checks = 0;
    n_fail   = 0;
    RST      = 1'b1;
    RAW_IN   = 4'b1010;
    repeat (5) @(negedge CLK);
    RST = 1'b0;
    repeat (300) @(negedge CLK);

    // Channel 0 clean rise.
    RAW_IN[0] = 1'b1;
    repeat (300) @(negedge CLK);

    // Channel 1: settle low, then rise with a one-cycle bounce after three ticks.
    RAW_IN[1] = 1'b0;
    repeat (300) @(negedge CLK);
    after_tick();
    RAW_IN[1] = 1'b1;
    repeat (155) @(negedge CLK);
    RAW_IN[1] = 1'b0;
    @(negedge CLK);
    RAW_IN[1] = 1'b1;
    repeat (300) @(negedge CLK);

    // Channels 2 and 3 toggle together in opposite directions.
    RAW_IN[3:2] = 2'b01;
    repeat (300) @(negedge CLK);

    // Asynchronous reset while channel 0 is three ticks into a pending fall.
    after_tick();
    RAW_IN[0] = 1'b0;
    repeat (155) @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    check("async_rst_level", OUT_LEVEL, 4'b0000);
    check("async_rst_pulses", {OUT_CHANGED, OUT_FALL, OUT_RISE}, 9'h0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (300) @(negedge CLK);

    // One-cycle glitches on channel 2 every 100 clocks must be rejected.
    for (int k = 0; k < 6; k++) begin
      RAW_IN[2] = ~RAW_IN[2];
      @(negedge CLK);
      RAW_IN[2] = ~RAW_IN[2];
      repeat (99) @(negedge CLK);
    end

    // Random patterns with random hold times, many shorter than the debounce window.
    for (int k = 0; k < 30; k++) begin
      RAW_IN = W'($urandom);
      repeat ($urandom_range(1, 260)) @(negedge CLK);
    end
    repeat (300) @(negedge CLK);

    guard = 0;
    while (sbq.size() > 0 && guard < 500) begin
      @(negedge CLK);
      guard++;
    end
    check("scoreboard_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
